// File: rtl/id_branch_resolver.sv
// ID-stage control-flow resolver with a bimodal branch history table.
// Resolves jumps and branches, drives the IF redirect and keeps branch statistics.
module id_branch_resolver #(
    parameter int ISA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH = 26,
    parameter int BHT_DEPTH     = 64,
    parameter int STAT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ISA_WIDTH-1:0]  if_pc,
    output logic                  if_predict_taken,
    input  logic [ISA_WIDTH-1:0]  id_pc,
    input  logic [ISA_WIDTH-1:0]  id_instruction,
    input  logic                  id_predicted_taken,
    input  logic                  id_no_op,
    input  logic                  id_stall,
    input  logic                  branch_instruction,
    input  logic                  j_instruction,
    input  logic                  jal_instruction,
    input  logic                  jr_instruction,
    input  logic                  condition_satisfied,
    input  logic [ISA_WIDTH-1:0]  id_reg_1,
    input  logic [ISA_WIDTH-1:0]  id_sign_extend_result,
    output logic                  pc_overload,
    output logic [ISA_WIDTH-1:0]  pc_overload_value,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [1:0]            bht_q [BHT_DEPTH];
    logic [STAT_WIDTH-1:0] bc_q, bc_d;
    logic [STAT_WIDTH-1:0] mc_q, mc_d;

    logic [IDX-1:0]       if_idx;
    logic [IDX-1:0]       id_idx;
    logic [1:0]           ctr_cur;
    logic [1:0]           ctr_d;
    logic                 act;
    logic                 any_jump;
    logic                 br_act;
    logic                 mis_taken;
    logic                 mis_nt;
    logic [ISA_WIDTH-1:0] seq;
    logic [ISA_WIDTH-1:0] btgt;
    logic [ISA_WIDTH-1:0] jtgt;
    logic                 unused_bits;

    assign if_idx = if_pc[IDX+1:2];
    assign id_idx = id_pc[IDX+1:2];

    assign act      = ~id_no_op & ~id_stall;
    assign any_jump = j_instruction | jal_instruction | jr_instruction;

    // A branch only trains and counts when no jump flag competes with it.
    assign br_act    = act & branch_instruction & ~any_jump;
    assign mis_taken = br_act & condition_satisfied & ~id_predicted_taken;
    assign mis_nt    = br_act & ~condition_satisfied & id_predicted_taken;

    assign seq  = id_pc + ISA_WIDTH'(4);
    assign btgt = seq + (id_sign_extend_result << 2);
    assign jtgt = {id_pc[ISA_WIDTH-1:ADDRESS_WIDTH+2],
                   id_instruction[ADDRESS_WIDTH-1:0], 2'b00};

    // Prediction reads the stored counter; a same-cycle write is not bypassed.
    assign if_predict_taken = bht_q[if_idx][1];
    assign ctr_cur          = bht_q[id_idx];

    assign branch_count     = bc_q;
    assign mispredict_count = mc_q;

    assign unused_bits = ^{if_pc[ISA_WIDTH-1:IDX+2], if_pc[1:0],
                           id_instruction[ISA_WIDTH-1:ADDRESS_WIDTH]};

    // Redirect selection: jumps first, then branch mispredictions.
    always_comb begin
        pc_overload       = 1'b0;
        pc_overload_value = seq;
        if (act & (j_instruction | jal_instruction)) begin
            pc_overload       = 1'b1;
            pc_overload_value = jtgt;
        end else if (act & jr_instruction) begin
            pc_overload       = 1'b1;
            pc_overload_value = id_reg_1;
        end else if (mis_taken) begin
            pc_overload       = 1'b1;
            pc_overload_value = btgt;
        end else if (mis_nt) begin
            pc_overload       = 1'b1;
            pc_overload_value = seq;
        end
    end

    // Saturating 2-bit step of the counter addressed by the ID branch.
    always_comb begin
        ctr_d = ctr_cur;
        if (condition_satisfied) begin
            if (ctr_cur != 2'b11) begin
                ctr_d = ctr_cur + 2'b01;
            end
        end else begin
            if (ctr_cur != 2'b00) begin
                ctr_d = ctr_cur - 2'b01;
            end
        end
    end

    // Saturating next values of the branch and mispredict statistics.
    always_comb begin
        bc_d = bc_q;
        mc_d = mc_q;
        if (br_act && (bc_q != '1)) begin
            bc_d = bc_q + STAT_WIDTH'(1);
        end
        if ((mis_taken | mis_nt) && (mc_q != '1)) begin
            mc_d = mc_q + STAT_WIDTH'(1);
        end
    end

    // BHT storage: reset to weakly not-taken, trained by resolved branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (br_act) begin
            bht_q[id_idx] <= ctr_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bc_q <= '0;
            mc_q <= '0;
        end else begin
            bc_q <= bc_d;
            mc_q <= mc_d;
        end
    end

    // The decoder never flags a branch and a jump together.
    always_ff @(posedge clk) begin
        if (!rst && act) begin
            assert (!(branch_instruction && any_jump));
        end
    end

endmodule

// File: tb/tb_id_branch_resolver.sv
// Scoreboard bench for id_branch_resolver.
// Driver queues expectations; a negedge monitor pops and compares them.
module tb_id_branch_resolver;

    localparam int K_OVL  = 0;
    localparam int K_OVV  = 1;
    localparam int K_PRED = 2;
    localparam int K_BC   = 3;
    localparam int K_MC   = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_predict_taken;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_predicted_taken;
    logic        id_no_op;
    logic        id_stall;
    logic        branch_instruction;
    logic        j_instruction;
    logic        jal_instruction;
    logic        jr_instruction;
    logic        condition_satisfied;
    logic [31:0] id_reg_1;
    logic [31:0] id_sign_extend_result;
    logic        pc_overload;
    logic [31:0] pc_overload_value;
    logic [3:0]  branch_count;
    logic [3:0]  mispredict_count;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          cyc = 0;
    int          napplied = 0;
    int          nmis = 0;

    id_branch_resolver #(
        .ISA_WIDTH    (32),
        .ADDRESS_WIDTH(26),
        .BHT_DEPTH    (64),
        .STAT_WIDTH   (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_pc                (if_pc),
        .if_predict_taken     (if_predict_taken),
        .id_pc                (id_pc),
        .id_instruction       (id_instruction),
        .id_predicted_taken   (id_predicted_taken),
        .id_no_op             (id_no_op),
        .id_stall             (id_stall),
        .branch_instruction   (branch_instruction),
        .j_instruction        (j_instruction),
        .jal_instruction      (jal_instruction),
        .jr_instruction       (jr_instruction),
        .condition_satisfied  (condition_satisfied),
        .id_reg_1             (id_reg_1),
        .id_sign_extend_result(id_sign_extend_result),
        .pc_overload          (pc_overload),
        .pc_overload_value    (pc_overload_value),
        .branch_count         (branch_count),
        .mispredict_count     (mispredict_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            case (mon_e.kind)
                K_OVL:   mon_act = {31'b0, pc_overload};
                K_OVV:   mon_act = pc_overload_value;
                K_PRED:  mon_act = {31'b0, if_predict_taken};
                K_BC:    mon_act = {28'b0, branch_count};
                default: mon_act = {28'b0, mispredict_count};
            endcase
            napplied++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
                nmis++;
                $display("FAIL %s: got %h expected %h (cycle %0d/%0d)",
                         mon_e.nm, mon_act, mon_e.val, cyc, mon_e.cyc);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v,
                            input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = v;
        e.nm   = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_pc                 = 32'h0000_0100;
        id_instruction        = '0;
        id_predicted_taken    = 1'b0;
        id_no_op              = 1'b0;
        id_stall              = 1'b0;
        branch_instruction    = 1'b0;
        j_instruction         = 1'b0;
        jal_instruction       = 1'b0;
        jr_instruction        = 1'b0;
        condition_satisfied   = 1'b0;
        id_reg_1              = '0;
        id_sign_extend_result = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic br_drive(input logic [31:0] pc, input logic [31:0] imm,
                            input logic taken, input logic pred);
        idle();
        id_pc                 = pc;
        branch_instruction    = 1'b1;
        id_sign_extend_result = imm;
        condition_satisfied   = taken;
        id_predicted_taken    = pred;
    endtask

    task automatic br(input logic [31:0] pc, input logic [31:0] imm,
                      input logic taken, input logic pred,
                      input logic eovl, input logic [31:0] eval,
                      input string nm);
        br_drive(pc, imm, taken, pred);
        expect_v(K_OVL, {31'b0, eovl}, {nm, "_ovl"});
        expect_v(K_OVV, eval, {nm, "_val"});
        step();
    endtask

    task automatic chk_pred(input logic [31:0] pc, input logic e,
                            input string nm);
        idle();
        if_pc = pc;
        expect_v(K_PRED, {31'b0, e}, nm);
        step();
    endtask

    task automatic chk_stats(input int bc, input int mc, input string nm);
        idle();
        expect_v(K_BC, 32'(bc), {nm, "_bc"});
        expect_v(K_MC, 32'(mc), {nm, "_mc"});
        step();
    endtask

    initial begin
        if_pc = '0;
        do_reset();

        // reset sweep
        for (int a = 0; a < 256; a += 4) begin
            chk_pred(32'(a), 1'b0, "reset_pred");
        end
        chk_stats(0, 0, "reset_stats");

        // training at 0x40
        if_pc = 32'h40;
        expect_v(K_PRED, 32'd0, "same_cycle_old_pred");
        br(32'h40, 32'd3, 1'b1, 1'b0, 1'b1, 32'h50, "br40_mis");
        chk_pred(32'h40, 1'b1, "pred40_after1");
        chk_stats(1, 1, "stats40_1");
        br(32'h40, 32'd3, 1'b1, 1'b1, 1'b0, 32'h44, "br40_ok");
        chk_pred(32'h40, 1'b1, "pred40_after2");
        chk_stats(2, 1, "stats40_2");
        br(32'h40, 32'd3, 1'b1, 1'b1, 1'b0, 32'h44, "br40_sat");
        br(32'h40, 32'd3, 1'b0, 1'b1, 1'b1, 32'h44, "br40_nt");
        chk_pred(32'h40, 1'b1, "pred40_sat11");
        chk_stats(4, 2, "stats40_4");

        // not-taken training and aliasing at 0x80 / 0x180
        do_reset();
        br(32'h80, 32'd2, 1'b1, 1'b0, 1'b1, 32'h8C, "br80_a");
        br(32'h80, 32'd2, 1'b1, 1'b1, 1'b0, 32'h84, "br80_b");
        br(32'h80, 32'd5, 1'b0, 1'b1, 1'b1, 32'h84, "br80_c");
        chk_pred(32'h80, 1'b1, "pred80_10");
        br(32'h180, 32'd5, 1'b0, 1'b1, 1'b1, 32'h184, "br180_d");
        chk_pred(32'h80, 1'b0, "pred80_alias01");
        br(32'h180, 32'd5, 1'b0, 1'b0, 1'b0, 32'h184, "br180_e");
        br(32'h180, 32'd5, 1'b0, 1'b0, 1'b0, 32'h184, "br180_f");
        chk_pred(32'h80, 1'b0, "pred80_sat00");
        br(32'h80, 32'd2, 1'b1, 1'b0, 1'b1, 32'h8C, "br80_g");
        chk_pred(32'h80, 1'b0, "pred80_01");
        chk_pred(32'h84, 1'b0, "pred84_untouched");
        chk_stats(7, 4, "stats80");

        // jumps
        do_reset();
        idle();
        id_pc          = 32'h0040_0000;
        id_instruction = 32'h0800_0010;
        j_instruction  = 1'b1;
        expect_v(K_OVL, 32'd1, "j_ovl");
        expect_v(K_OVV, 32'h40, "j_val");
        step();
        idle();
        id_pc           = 32'h3000_0000;
        id_instruction  = 32'h0C00_0010;
        jal_instruction = 1'b1;
        expect_v(K_OVL, 32'd1, "jal_ovl");
        expect_v(K_OVV, 32'h3000_0040, "jal_val");
        step();
        idle();
        jr_instruction = 1'b1;
        id_reg_1       = 32'h1234;
        expect_v(K_OVL, 32'd1, "jr_ovl");
        expect_v(K_OVV, 32'h1234, "jr_val");
        step();
        idle();
        expect_v(K_OVL, 32'd0, "idle_ovl");
        expect_v(K_OVV, 32'h104, "idle_val");
        step();
        chk_pred(32'h0, 1'b0, "jump_no_train");
        chk_stats(0, 0, "jump_stats");

        // stall then release
        do_reset();
        for (int i = 0; i < 3; i++) begin
            br_drive(32'h40, 32'd3, 1'b1, 1'b0);
            id_stall = 1'b1;
            expect_v(K_OVL, 32'd0, "stall_ovl");
            expect_v(K_OVV, 32'h44, "stall_val");
            step();
        end
        chk_pred(32'h40, 1'b0, "stall_no_train");
        br(32'h40, 32'd3, 1'b1, 1'b0, 1'b1, 32'h50, "release");
        chk_pred(32'h40, 1'b1, "release_train");
        chk_stats(1, 1, "release_stats");

        // bubbles
        for (int i = 0; i < 3; i++) begin
            br_drive(32'h200, 32'd3, 1'b1, 1'b0);
            id_no_op = 1'b1;
            expect_v(K_OVL, 32'd0, "noop_ovl");
            expect_v(K_OVV, 32'h204, "noop_val");
            step();
        end
        idle();
        id_no_op      = 1'b1;
        j_instruction = 1'b1;
        expect_v(K_OVL, 32'd0, "noop_j_ovl");
        step();
        chk_pred(32'h200, 1'b0, "noop_no_train");
        chk_stats(1, 1, "noop_stats");

        // statistic saturation and reset over training
        do_reset();
        for (int i = 0; i < 20; i++) begin
            br(32'h10, 32'd1, 1'b1, 1'b0, 1'b1, 32'h18, "sat_br");
        end
        chk_stats(15, 15, "stats_sat");
        chk_pred(32'h10, 1'b1, "pred10_trained");
        br_drive(32'h10, 32'd1, 1'b1, 1'b0);
        rst = 1'b1;
        expect_v(K_OVL, 32'd1, "rst_comb_ovl");
        expect_v(K_OVV, 32'h18, "rst_comb_val");
        step();
        rst = 1'b0;
        chk_pred(32'h10, 1'b0, "rst_over_train");
        chk_stats(0, 0, "rst_stats");

        step();
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            step();
        end
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 napplied, nmis);
        $finish;
    end

endmodule

// File: doc/id_branch_resolver.md
# id_branch_resolver

Parametrised ID-stage control-flow resolver for the five-stage pipeline. It resolves jumps and conditional branches in ID and owns a bimodal branch history table (BHT) of 2-bit saturating counters. The BHT supplies an IF-stage taken prediction and is trained when branches resolve in ID. On a jump or a branch misprediction it produces a single PC-overload redirect to `instruction_mem` and `if_id_reg`, and it keeps saturating branch and mispredict statistics for the debug unit.

## Interface
Parameters:
- `ISA_WIDTH`, 32: datapath and PC width.
- `ADDRESS_WIDTH`, 26: J-type target field width.
- `BHT_DEPTH`, 64: number of counters; power of two, minimum 2.
- `STAT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `if_pc`  in  ISA_WIDTH: PC of the instruction currently in IF.
- `if_predict_taken`  out  1: prediction for `if_pc`.
- `id_pc`  in  ISA_WIDTH: address of the instruction in ID.
- `id_instruction`  in  ISA_WIDTH: instruction in ID.
- `id_predicted_taken`  in  1: prediction carried by `if_id_reg`.
- `id_no_op`  in  1: ID holds a bubble.
- `id_stall`  in  1: ID is held this cycle.
- `branch_instruction`, `j_instruction`, `jal_instruction`, `jr_instruction`  in  1 each: decoded instruction class.
- `condition_satisfied`  in  1: branch condition result.
- `id_reg_1`  in  ISA_WIDTH: rs value, used as the jr target.
- `id_sign_extend_result`  in  ISA_WIDTH: sign-extended immediate.
- `pc_overload`  out  1: redirect IF this cycle.
- `pc_overload_value`  out  ISA_WIDTH: redirect target.
- `branch_count`  out  STAT_WIDTH: resolved branches.
- `mispredict_count`  out  STAT_WIDTH: mispredicted branches.

## Operation
Definitions:
- `IDX = log2(BHT_DEPTH)`.
- Index of an address `a` is `a[IDX+1:2]`; addresses alias modulo `4*BHT_DEPTH`.
- `act = ~id_no_op & ~id_stall`.
- `seq = id_pc + 4`.
- `btgt = id_pc + 4 + (id_sign_extend_result << 2)`, truncated to ISA_WIDTH with wrap-around.
- `jtgt = {id_pc[ISA_WIDTH-1:ADDRESS_WIDTH+2], id_instruction[ADDRESS_WIDTH-1:0], 2'b00}`.
- The architecture has no delay slots.

Prediction:
- `if_predict_taken` is bit 1 of counter[index(if_pc)]. It is a combinational read of the stored value and never bypasses a same-cycle write.

Redirect (combinational), in priority order:
1. `act & (j|jal)`: overload to `jtgt`.
2. `act & jr`: overload to `id_reg_1`.
3. `act & branch & condition_satisfied & ~id_predicted_taken`: overload to `btgt`.
4. `act & branch & ~condition_satisfied & id_predicted_taken`: overload to `seq`.
- Otherwise `pc_overload = 0` and `pc_overload_value = seq`.
- A correctly predicted branch produces no redirect. IF has already fetched `btgt` or `seq` itself.

Training, on an edge where `act & branch` is true (`rst` low):
- counter[index(id_pc)] increments if `condition_satisfied`, otherwise decrements.
- Counters saturate at 2'b11 and 2'b00.
- A write and a read of the same index in one cycle: the read returns the old value; the new value is visible the next cycle.

Statistics, on the same edge condition:
- `branch_count` increments by 1.
- `mispredict_count` increments by 1 when the branch matched case 3 or case 4.
- Both counters saturate at all-ones and never wrap.

Reset:
- Every counter is set to 2'b01 (weakly not-taken). After reset, `if_predict_taken = 0` for every PC.
- `branch_count = 0` and `mispredict_count = 0`.
- The combinational outputs follow their inputs during reset, but no state changes other than the reset itself.
- A `rst` asserted mid-operation overrides any training in the same edge.

## Timing
- Prediction: 0 cycles, combinational from `if_pc`.
- Redirect: 0 cycles, combinational in the resolving cycle. `if_id_reg` flushes on `pc_overload`.
- BHT and statistics: updated at the end of the resolving cycle and visible 1 cycle later.
- Stall: while `id_stall` is high there is no redirect, no training and no statistics update. The instruction resolves once, on its unstalled cycle.
- Bubble: `id_no_op` suppresses all effects, even if stale class bits are high.
- Simultaneous jump and branch flags: the jump wins and no training occurs. The decoder must not raise both; this is checked by assertion.

## Test plan
- Reset, then sweep `if_pc` over 0x00–0xFC: `if_predict_taken = 0` everywhere and both statistics read 0.
- Branch at `id_pc = 0x40`, taken, predicted 0, imm 3: `pc_overload = 1` with value 0x50. Counter 01→10, and `if_pc = 0x40` now predicts 1. Repeat with predicted 1: no overload, counter saturates at 11. Stats end at branch 2, mispredict 1.
- Predicted-taken branch at 0x80, not taken: overload to 0x84, counter decrements. Issue a further not-taken branch at `0x80 + 4*BHT_DEPTH`: the same counter, via aliasing, saturates at 00.
- j with target field 0x0000010 at `id_pc = 0x00400000`: value 0x00000040. jr with `id_reg_1 = 0x1234`: value 0x1234. Neither changes the BHT or the statistics.
- Taken branch held with `id_stall` for 3 cycles, then released: exactly one overload (on release), one counter step and branch_count +1. The same test with `id_no_op = 1`: no effect at all.
- With `STAT_WIDTH = 4`, resolve 20 mispredicted branches: both counters hold at 15. Assert `rst` on the same edge as a training event: the counter goes to 01 and the statistics to 0.
